hs_angle_fetcher: RTL

- Consumer end of the host angle interface: requests angles with hs_next_angle and accepts them on hs_next_angle_ack / hs_has_next_angle.
- Each angle is handed to the projection engine (pe_*) with a one-cycle start pulse. The block waits for the engine's done, then fetches the next angle.
- Sits between the host angle source and the backprojection engine. Reports busy, finished and the count of angles issued.

---
 rtl/hs_angle_fetcher.sv | 134 +++++++++++++
 1 files changed

// File: rtl/hs_angle_fetcher.sv
// Fetches angles from the host angle source and issues them one at a time to the projection engine.
// Optional HS_ANGLE_FETCHER_PREFETCH_EN: prefetch the next angle into a shadow register while the engine runs.
`ifndef kAngleLength
`define kAngleLength 16
`endif

module hs_angle_fetcher #(
  parameter int unsigned angle_width = `kAngleLength,
  parameter int unsigned count_width = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fa_start,
  input  logic [angle_width-1:0] hs_angle,
  input  logic                   hs_has_next_angle,
  input  logic                   hs_next_angle_ack,
  output logic                   hs_next_angle,
  output logic [angle_width-1:0] pe_angle,
  output logic                   pe_start,
  input  logic                   pe_done,
  output logic                   fa_busy,
  output logic                   fa_finished,
  output logic [count_width-1:0] fa_angle_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT_DONE,
    S_ADVANCE,
    S_FINISHED
  } state_t;

  state_t state, next_state;
  logic   sweep_start;

`ifdef HS_ANGLE_FETCHER_PREFETCH_EN
  logic [angle_width-1:0] shadow;
  logic                   shadow_valid;
  logic                   pf_pending;
  logic                   pf_last;
  logic                   pf_req;
`endif

  assign sweep_start = fa_start && ((state == S_IDLE) || (state == S_FINISHED));

  // Next-state and host request
  always_comb begin
    next_state    = state;
    hs_next_angle = 1'b0;
`ifdef HS_ANGLE_FETCHER_PREFETCH_EN
    pf_req        = 1'b0;
`endif
    case (state)
      S_IDLE, S_FINISHED: if (fa_start) next_state = S_LOAD;
      S_LOAD:             next_state = S_ISSUE;
      S_ISSUE:            next_state = S_WAIT_DONE;
      S_WAIT_DONE: begin
`ifdef HS_ANGLE_FETCHER_PREFETCH_EN
        pf_req        = !shadow_valid && !pf_pending && !pf_last && hs_has_next_angle;
        hs_next_angle = pf_req;
        if (pe_done) begin
          // An accepted prefetch (now or earlier) goes straight to LOAD, never requesting twice
          if (shadow_valid || pf_pending || (pf_req && hs_next_angle_ack)) next_state = S_LOAD;
          else if (pf_last || !hs_has_next_angle)                           next_state = S_FINISHED;
          else                                                              next_state = S_ADVANCE;
        end
`else
        if (pe_done) next_state = S_ADVANCE;
`endif
      end
      S_ADVANCE: begin
        if (hs_has_next_angle) begin
          hs_next_angle = 1'b1;
          if (hs_next_angle_ack) next_state = S_LOAD;
        end else begin
          next_state = S_FINISHED;
        end
      end
      default: next_state = S_IDLE;
    endcase
    if (reset) hs_next_angle = 1'b0;
  end

  // State, engine interface and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      pe_angle       <= '0;
      pe_start       <= 1'b0;
      fa_busy        <= 1'b0;
      fa_finished    <= 1'b0;
      fa_angle_count <= '0;
`ifdef HS_ANGLE_FETCHER_PREFETCH_EN
      shadow         <= '0;
      shadow_valid   <= 1'b0;
      pf_pending     <= 1'b0;
      pf_last        <= 1'b0;
`endif
    end else begin
      state    <= next_state;
      pe_start <= (next_state == S_ISSUE);
      fa_busy  <= (next_state != S_IDLE) && (next_state != S_FINISHED);
      if (sweep_start) begin
        fa_angle_count <= '0;
        fa_finished    <= 1'b0;
      end
      if ((next_state == S_FINISHED) && (state != S_FINISHED)) fa_finished <= 1'b1;
      if ((next_state == S_ISSUE) && (fa_angle_count != '1))
        fa_angle_count <= fa_angle_count + count_width'(1);
`ifdef HS_ANGLE_FETCHER_PREFETCH_EN
      if (state == S_LOAD) pe_angle <= shadow_valid ? shadow : hs_angle;
      if (pf_req && hs_next_angle_ack) pf_pending <= 1'b1;
      // The acked angle becomes visible on hs_angle one cycle after the ack
      if (pf_pending) begin
        shadow       <= hs_angle;
        shadow_valid <= 1'b1;
        pf_pending   <= 1'b0;
      end
      if ((state == S_WAIT_DONE) && !shadow_valid && !pf_pending && !hs_has_next_angle)
        pf_last <= 1'b1;
      if ((state == S_LOAD) || sweep_start) begin
        shadow_valid <= 1'b0;
        pf_pending   <= 1'b0;
        pf_last      <= 1'b0;
      end
`else
      if (state == S_LOAD) pe_angle <= hs_angle;
`endif
    end
  end

endmodule
